// File: rtl/r200_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate formats.
package r200_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } aluop_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immfmt_e;

  typedef struct packed {
    aluop_e aluop;
    logic   alusrc;
    logic   regwr;
    logic   memrd;
    logic   memwr;
    logic   branch;
    logic   jump;
  } ctrl_t;

  function automatic logic [31:0] imm_gen(input immfmt_e fmt, input logic [31:0] ins);
    case (fmt)
      IMM_I:   imm_gen = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm_gen = {ins[31:12], 12'b0};
      IMM_J:   imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm_gen = 32'b0;
    endcase
  endfunction

  function automatic aluop_e alu_from_f3(input logic [2:0] f3, input logic sub_en, input logic sra_en);
    case (f3)
      3'b000:  alu_from_f3 = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Pure combinational RV32I decoder: control bits, immediate, source-register usage.
// Illegal encodings (unknown opcode, bad funct7) come out with all control cleared.
module instr_decode
  import r200_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [31:0] imm_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rd_o,
  output logic        use_rs1_o,
  output logic        use_rs2_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;
  immfmt_e    fmt;

  assign opcode = instr_i[6:0];
  assign f7     = instr_i[31:25];
  assign f3     = instr_i[14:12];
  assign rd_o   = instr_i[11:7];

  always_comb begin
    ctrl_o    = '0;
    fmt       = IMM_NONE;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    illegal_o = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl_o.regwr = 1'b1; ctrl_o.alusrc = 1'b1; ctrl_o.aluop = ALU_PASSB; fmt = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_o.regwr = 1'b1; ctrl_o.alusrc = 1'b1; fmt = IMM_U;
      end
      OPC_JAL: begin
        ctrl_o.regwr = 1'b1; ctrl_o.jump = 1'b1; fmt = IMM_J;
      end
      OPC_JALR: begin
        ctrl_o.regwr = 1'b1; ctrl_o.jump = 1'b1; ctrl_o.alusrc = 1'b1; fmt = IMM_I;
        use_rs1_o = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.branch = 1'b1; ctrl_o.aluop = ALU_SUB; fmt = IMM_B;
        use_rs1_o = 1'b1; use_rs2_o = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.memrd = 1'b1; ctrl_o.regwr = 1'b1; ctrl_o.alusrc = 1'b1; fmt = IMM_I;
        use_rs1_o = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.memwr = 1'b1; ctrl_o.alusrc = 1'b1; fmt = IMM_S;
        use_rs1_o = 1'b1; use_rs2_o = 1'b1;
      end
      OPC_OPIMM: begin
        // instr[30] is an immediate bit for ADDI, so only shifts look at it
        ctrl_o.regwr = 1'b1; ctrl_o.alusrc = 1'b1; fmt = IMM_I;
        ctrl_o.aluop = alu_from_f3(f3, 1'b0, instr_i[30]);
        use_rs1_o = 1'b1;
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000))
          illegal_o = 1'b1;
      end
      OPC_OP: begin
        ctrl_o.regwr = 1'b1;
        ctrl_o.aluop = alu_from_f3(f3, instr_i[30], instr_i[30]);
        use_rs1_o = 1'b1; use_rs2_o = 1'b1;
        if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o)
      ctrl_o = '0;
    if (rd_o == 5'd0)
      ctrl_o.regwr = 1'b0;
  end

  assign imm_o    = imm_gen(fmt, instr_i);
  assign funct3_o = illegal_o ? 3'b000 : f3;

endmodule

// File: rtl/idex_stage.sv
// RV32I decode stage and ID/EX register with load-use stall, bubble and flush control.
// Optional IDEX_ILLEGAL_TRAP_EN adds ex_illegal for unknown opcodes / bad funct7.
module idex_stage
  import r200_pkg::*;
#(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic [4:0]      rs1addr,
  output logic [4:0]      rs2addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_flush,
  input  logic            ex_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_aluop,
  output logic            ex_alusrc,
  output logic            ex_regwr,
  output logic            ex_memrd,
  output logic            ex_memwr,
  output logic [2:0]      ex_funct3,
  output logic            ex_branch,
  output logic            ex_jump
`ifdef IDEX_ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal
`endif
);

  ctrl_t       dec_ctrl;
  logic [31:0] dec_imm;
  logic [2:0]  dec_f3;
  logic [4:0]  dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_illegal;
  logic        hazard, bubble, load;

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;

  assign rs1addr = if_instr[19:15];
  assign rs2addr = if_instr[24:20];

  instr_decode u_dec (
    .instr_i   (if_instr),
    .ctrl_o    (dec_ctrl),
    .imm_o     (dec_imm),
    .funct3_o  (dec_f3),
    .rd_o      (dec_rd),
    .use_rs1_o (dec_use_rs1),
    .use_rs2_o (dec_use_rs2),
    .illegal_o (dec_illegal)
  );

  // An illegal encoding reads no operands, so it never waits on a load
  assign hazard = valid_q && ctrl_q.memrd && (rd_q != 5'd0) && if_valid && !dec_illegal &&
                  ((dec_use_rs1 && rd_q == rs1addr) || (dec_use_rs2 && rd_q == rs2addr));

  assign if_ready = ex_flush || (!ex_stall && !hazard);
  assign bubble   = ex_flush || (!ex_stall && (hazard || !if_valid));
  assign load     = !ex_flush && !ex_stall && !hazard && if_valid;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    if (bubble) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      f3_d    = 3'b000;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      f3_d    = dec_f3;
      rd_d    = dec_rd;
      pc_d    = if_pc;
      rs1_d   = rs1_data;
      rs2_d   = rs2_data;
      imm_d   = XLEN'($signed(dec_imm));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      f3_q    <= 3'b000;
      rd_q    <= 5'd0;
      pc_q    <= RESET_PC;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
    end
  end

`ifdef IDEX_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (bubble)
      illegal_d = 1'b0;
    else if (load)
      illegal_d = dec_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign ex_illegal = illegal_q;
`endif

  assign ex_valid  = valid_q;
  assign ex_pc     = pc_q;
  assign ex_rs1    = rs1_q;
  assign ex_rs2    = rs2_q;
  assign ex_imm    = imm_q;
  assign ex_rd     = rd_q;
  assign ex_aluop  = ctrl_q.aluop;
  assign ex_alusrc = ctrl_q.alusrc;
  assign ex_regwr  = ctrl_q.regwr;
  assign ex_memrd  = ctrl_q.memrd;
  assign ex_memwr  = ctrl_q.memwr;
  assign ex_funct3 = f3_q;
  assign ex_branch = ctrl_q.branch;
  assign ex_jump   = ctrl_q.jump;

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- Decode stage plus ID/EX pipeline register for the RV32I core.
- Takes the fetched instruction and drives the register file read addresses combinationally.
- Decodes opcode, immediate and control fields, then registers them with the register file read data toward execute.
- Detects load-use hazards and owns the stall, bubble and flush policy between fetch and execute.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediates.
- RESET_PC, 32'h0000_0000, value of ex_pc while in reset.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  32  fetched instruction.
- if_pc  in  XLEN  PC of if_instr.
- if_ready  out  1  stage accepts if_instr this cycle.
- rs1addr  out  5  register file read address 1; equals if_instr[19:15].
- rs2addr  out  5  register file read address 2; equals if_instr[24:20].
- rs1_data  in  XLEN  register file read data 1.
- rs2_data  in  XLEN  register file read data 2.
- ex_flush  in  1  branch or jump resolved taken in EX; kill the ID/EX contents.
- ex_stall  in  1  downstream cannot accept; hold the ID/EX contents.
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_pc  out  XLEN  PC of the instruction in EX.
- ex_rs1  out  XLEN  operand 1.
- ex_rs2  out  XLEN  operand 2.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rd  out  5  destination register.
- ex_aluop  out  4  ALU operation code (package enum).
- ex_alusrc  out  1  1 = use immediate as ALU operand B.
- ex_regwr  out  1  instruction writes rd.
- ex_memrd  out  1  load.
- ex_memwr  out  1  store.
- ex_funct3  out  3  passed through for branch compare and load/store size.
- ex_branch  out  1  conditional branch.
- ex_jump  out  1  JAL or JALR.
- ex_illegal  out  1  present only with the optional feature.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - All ex_* control outputs are 0; ex_valid=0.
  - ex_pc=RESET_PC; ex_rs1, ex_rs2, ex_imm and ex_rd are 0.
- Read data path:
  - The register file is read combinationally and written on negedge.
  - Writeback data from the same cycle is already visible on rs1_data/rs2_data, so no WB forwarding is done here.
- Decode (combinational):
  - Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediate formats I, S, B, U and J, each sign-extended to XLEN; bit 0 of the B and J immediates is 0.
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
  - Unknown opcodes decode as a NOP: all control 0, ex_regwr=0.
  - A decoded rd of 0 forces ex_regwr=0.
- Hazard (combinational): asserted when all of these hold:
  - ex_valid and ex_memrd;
  - ex_rd is not 0;
  - ex_rd equals a source register that the current opcode actually uses;
  - if_valid.
- if_ready = ex_flush OR (NOT ex_stall AND NOT hazard).
- Register update priority, evaluated each posedge, first match wins:
  1. ex_flush: ex_valid<=0, all control<=0. Overrides stall, and the fetched instruction is discarded.
  2. ex_stall: hold every ID/EX register.
  3. hazard: insert a bubble (ex_valid<=0, control<=0). Fetch is held by if_ready=0, and the instruction re-decodes the next cycle, giving exactly 1 bubble per load-use.
  4. if_valid: load the decoded fields and rs1_data/rs2_data; ex_valid<=1.
  5. Otherwise: bubble.
- Latency: 1 cycle from accept to ex_valid.
- Datapath registers may hold stale data under a bubble. Only control outputs are guaranteed 0.
- Reset mid-operation: immediate return to the reset values; any in-flight instruction is lost.

Optional Feature:
- Macro: IDEX_ILLEGAL_TRAP_EN.
- When defined:
  - ex_illegal output exists.
  - It is set to 1 for an unknown opcode, or for OP/OP-IMM with an invalid funct7 encoding.
  - It registers like a control bit; all other control is forced to 0.
  - A flush clears it.
- When undefined: no ex_illegal port, and illegal encodings silently decode as NOP.

Decomposition:
- Package r200_pkg holds:
  - opcode localparams;
  - the aluop enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB (LUI);
  - the immediate-format enum;
  - the NOP instruction constant 32'h0000_0013.
- One sub-module: instr_decode, the pure combinational decoder (control plus immediate generation). The hazard logic and pipeline register stay in idex_stage.

Test Plan:
- Reset: hold rst_n=0 with if_valid=1 -> ex_valid=0, ex_regwr=0, ex_pc=RESET_PC. After release, ADDI x1,x0,5 (32'h0050_0093) -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_alusrc=1, ex_aluop=ADD.
- Immediates:
  - SW x2,-4(x1) -> ex_imm=32'hFFFF_FFFC, ex_memwr=1, ex_regwr=0.
  - BEQ offset -8 -> ex_imm=32'hFFFF_FFF8.
  - JAL offset +2048 -> ex_imm=32'h0000_0800.
- Load-use: LW x5,0(x1) followed by ADD x6,x5,x7 -> if_ready=0 for 1 cycle, one bubble with ex_valid=0, then ADD is issued. LW x5 followed by LUI x5 -> no stall.
- Stall versus flush: ex_stall=1 for 3 cycles -> ID/EX registers unchanged and if_ready=0. ex_flush=1 together with ex_stall=1 -> ex_valid=0 next cycle and if_ready=1.
- rd=x0 and unknown opcode: ADD x0,x1,x2 -> ex_regwr=0. Opcode 7'b1111111 -> all control 0; with IDEX_ILLEGAL_TRAP_EN, ex_illegal=1.
- Read-after-negedge-write: the register file writes x3=32'hDEAD_BEEF in the same cycle that ADD x4,x3,x0 is decoded -> ex_rs1=32'hDEAD_BEEF.
